// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core front end.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall/flush control and rs1/rs2 extraction.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        valid,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    // flush beats load beats stall; otherwise a bubble is inserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= load_pc;
            instr <= load_instr;
            valid <= 1'b1;
        end else if (!stall) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end
    end

    assign rs1 = valid ? instr[RS1_MSB:RS1_LSB] : 5'd0;
    assign rs2 = valid ? instr[RS2_MSB:RS2_LSB] : 5'd0;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, single-outstanding imem requests, hold buffer, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds stall and fetch counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          XLEN     = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Hazard_i,
    input  logic        Flush_i,
    input  logic [31:0] BranchTarget_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] IF_IDpc_o,
    output logic [31:0] IF_IDinstr_o,
    output logic        IF_IDvalid_o,
    output logic [4:0]  IF_IDrs1_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [4:0]  IF_IDrs2_o,
    output logic [31:0] StallCnt_o,
    output logic [31:0] FetchCnt_o
`else
    output logic [4:0]  IF_IDrs2_o
`endif
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] pc_issued, pc_issued_nxt;
    logic [XLEN-1:0] hold_pc, hold_pc_nxt;
    logic [31:0]     hold_instr, hold_instr_nxt;
    logic            kill, kill_nxt;
    logic            ifid_load;
    logic [31:0]     ifid_load_pc, ifid_load_instr;
    logic            free;
    logic [31:0]     target;
    logic            unused_tgt_lsb;

    assign free           = !Hazard_i || !IF_IDvalid_o;
    assign target         = {BranchTarget_i[31:2], 2'b00};
    assign unused_tgt_lsb = ^BranchTarget_i[1:0];
    assign imem_req_o     = (state == REQ) && !rst_i;
    assign imem_addr_o    = {pc[31:2], 2'b00};

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        pc_issued_nxt   = pc_issued;
        hold_pc_nxt     = hold_pc;
        hold_instr_nxt  = hold_instr;
        kill_nxt        = kill;
        ifid_load       = 1'b0;
        ifid_load_pc    = hold_pc;
        ifid_load_instr = hold_instr;
        unique case (state)
            REQ: begin
                if (imem_gnt_i) begin
                    pc_issued_nxt = pc;
                    pc_nxt        = pc + 32'd4;
                    state_nxt     = WAIT;
                    // a grant coinciding with a redirect fetched the wrong path
                    kill_nxt      = Flush_i;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_nxt = REQ;
                    kill_nxt  = 1'b0;
                    if (!kill && !Flush_i) begin
                        if (free) begin
                            ifid_load       = 1'b1;
                            ifid_load_pc    = pc_issued;
                            ifid_load_instr = imem_rdata_i;
                        end else begin
                            state_nxt      = HOLD;
                            hold_pc_nxt    = pc_issued;
                            hold_instr_nxt = imem_rdata_i;
                        end
                    end
                end else if (Flush_i) begin
                    kill_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (Flush_i) begin
                    state_nxt = REQ;
                end else if (!Hazard_i) begin
                    ifid_load = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
        if (Flush_i) begin
            pc_nxt = target;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= REQ;
            pc         <= RESET_PC;
            pc_issued  <= '0;
            hold_pc    <= '0;
            hold_instr <= NOP_INSTR;
            kill       <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pc_issued  <= pc_issued_nxt;
            hold_pc    <= hold_pc_nxt;
            hold_instr <= hold_instr_nxt;
            kill       <= kill_nxt;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk_i),
        .rst        (rst_i),
        .flush      (Flush_i),
        .stall      (Hazard_i),
        .load       (ifid_load),
        .load_pc    (ifid_load_pc),
        .load_instr (ifid_load_instr),
        .pc         (IF_IDpc_o),
        .instr      (IF_IDinstr_o),
        .valid      (IF_IDvalid_o),
        .rs1        (IF_IDrs1_o),
        .rs2        (IF_IDrs2_o)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            StallCnt_o <= '0;
            FetchCnt_o <= '0;
        end else begin
            if (Hazard_i && IF_IDvalid_o) begin
                StallCnt_o <= StallCnt_o + 32'd1;
            end
            if (ifid_load) begin
                FetchCnt_o <= FetchCnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage against a transaction-level model.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        Hazard_i = 1'b0;
    logic        Flush_i = 1'b0;
    logic [31:0] BranchTarget_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] IF_IDpc_o;
    logic [31:0] IF_IDinstr_o;
    logic        IF_IDvalid_o;
    logic [4:0]  IF_IDrs1_o;
    logic [4:0]  IF_IDrs2_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .Hazard_i       (Hazard_i),
        .Flush_i        (Flush_i),
        .BranchTarget_i (BranchTarget_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .IF_IDpc_o      (IF_IDpc_o),
        .IF_IDinstr_o   (IF_IDinstr_o),
        .IF_IDvalid_o   (IF_IDvalid_o),
        .IF_IDrs1_o     (IF_IDrs1_o),
        .IF_IDrs2_o     (IF_IDrs2_o)
    );

    // model: next fetch address, outstanding access, parked response, IF/ID
    logic [31:0] m_pc, m_issued, m_bpc, m_binstr, m_ipc, m_instr;
    bit          m_busy, m_stale, m_buf, m_v;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_issued = '0; m_bpc = '0; m_binstr = '0;
        m_busy = 0; m_stale = 0; m_buf = 0;
        m_v = 0; m_ipc = '0; m_instr = NOP_INSTR;
    endtask

    task automatic model_step(input bit hz, input bit fl, input bit gnt,
                              input bit rv, input logic [31:0] tgt,
                              input logic [31:0] rdata);
        bit req0     = !m_busy && !m_buf;
        bit free     = !hz || !m_v;
        bit resp     = m_busy && rv;
        bit good     = resp && !m_stale && !fl;
        bit from_buf = m_buf && !hz && !fl;
        if (fl) begin
            m_v = 0; m_instr = NOP_INSTR;
        end else if (good && free) begin
            m_v = 1; m_ipc = m_issued; m_instr = rdata;
        end else if (from_buf) begin
            m_v = 1; m_ipc = m_bpc; m_instr = m_binstr;
        end else if (!hz) begin
            m_v = 0; m_instr = NOP_INSTR;
        end
        if (fl || from_buf) m_buf = 0;
        else if (good && !free) begin
            m_buf = 1; m_bpc = m_issued; m_binstr = rdata;
        end
        if (resp) begin
            m_busy = 0; m_stale = 0;
        end else if (m_busy && fl) begin
            m_stale = 1;
        end
        if (req0 && gnt) begin
            m_busy = 1; m_stale = fl; m_issued = m_pc; m_pc = m_pc + 32'd4;
        end
        if (fl) m_pc = {tgt[31:2], 2'b00};
    endtask

    task automatic check_outputs();
        bit r = !m_busy && !m_buf && !rst_i;
        chk("req", 32'(imem_req_o), 32'(r));
        if (r) chk("addr", imem_addr_o, m_pc);
        chk("valid", 32'(IF_IDvalid_o), 32'(m_v));
        chk("instr", IF_IDinstr_o, m_v ? m_instr : NOP_INSTR);
        if (m_v) chk("pc", IF_IDpc_o, m_ipc);
        chk("rs1", 32'(IF_IDrs1_o), m_v ? 32'(m_instr[19:15]) : 32'd0);
        chk("rs2", 32'(IF_IDrs2_o), m_v ? 32'(m_instr[24:20]) : 32'd0);
    endtask

    task automatic tick(input bit hz, input bit fl, input bit gnt,
                        input bit rv, input logic [31:0] tgt,
                        input logic [31:0] rdata);
        Hazard_i = hz; Flush_i = fl; imem_gnt_i = gnt;
        imem_rvalid_i = rv; BranchTarget_i = tgt; imem_rdata_i = rdata;
        model_step(hz, fl, gnt, rv, tgt, rdata);
        @(posedge clk_i); #1;
        check_outputs();
    endtask

    initial begin
        bit          tb_out;
        int          tb_dly;
        logic [31:0] tb_addr;
        model_reset();
        @(posedge clk_i); #1;
        check_outputs();
        chk("rst_pc", IF_IDpc_o, 32'h0);
        rst_i = 1'b0;

        // back-to-back fetches, gnt immediately and rvalid one cycle later
        for (int i = 0; i < 2; i++) begin
            chk("seq_addr", imem_addr_o, 32'(i * 4));
            tick(0, 0, 1, 0, 0, 0);
            tick(0, 0, 0, 1, 0, (i == 1) ? 32'h00B5_0633 : memf(32'(i * 4)));
            chk("seq_ifpc", IF_IDpc_o, 32'(i * 4));
        end

        // load-use stall while the next response lands in the hold buffer
        chk("stall_addr", imem_addr_o, 32'h8);
        tick(1, 0, 1, 0, 0, 0);
        tick(1, 0, 0, 1, 0, memf(32'h8));
        chk("stall_rs1", 32'(IF_IDrs1_o), 32'd10);
        chk("stall_rs2", 32'(IF_IDrs2_o), 32'd11);
        tick(1, 0, 0, 0, 0, 0);
        chk("stall_pc", IF_IDpc_o, 32'h4);
        chk("hold_noreq", 32'(imem_req_o), 32'd0);
        tick(0, 0, 0, 0, 0, 0);
        chk("unhold_pc", IF_IDpc_o, 32'h8);
        chk("unhold_instr", IF_IDinstr_o, memf(32'h8));

        // flush during WAIT, response arrives next cycle and is dropped
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 32'h100, 0);
        tick(0, 0, 0, 1, 0, memf(32'hC));
        chk("kill_valid", 32'(IF_IDvalid_o), 32'd0);
        chk("kill_addr", imem_addr_o, 32'h100);

        // flush and hazard together
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 0, memf(32'h100));
        chk("pre_fh_valid", 32'(IF_IDvalid_o), 32'd1);
        tick(1, 1, 0, 0, 32'h203, 0);
        chk("fh_valid", 32'(IF_IDvalid_o), 32'd0);
        chk("fh_instr", IF_IDinstr_o, NOP_INSTR);
        chk("fh_addr", imem_addr_o, 32'h200);

        // grant withheld for four cycles
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            chk("nognt_req", 32'(imem_req_o), 32'd1);
            chk("nognt_addr", imem_addr_o, 32'h200);
        end
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 0, memf(32'h200));
        chk("nognt_ifpc", IF_IDpc_o, 32'h200);
        chk("next_addr", imem_addr_o, 32'h204);

        // flush in the same cycle as a grant
        tick(0, 1, 1, 0, 32'h300, 0);
        tick(0, 0, 0, 1, 0, memf(32'h204));
        chk("fg_valid", 32'(IF_IDvalid_o), 32'd0);
        chk("fg_addr", imem_addr_o, 32'h300);

        // asynchronous reset while waiting; late response must be ignored
        tick(0, 0, 1, 0, 0, 0);
        rst_i = 1'b1;
        #2;
        chk("arst_req", 32'(imem_req_o), 32'd0);
        chk("arst_valid", 32'(IF_IDvalid_o), 32'd0);
        chk("arst_instr", IF_IDinstr_o, NOP_INSTR);
        chk("arst_pc", IF_IDpc_o, 32'h0);
        model_reset();
        @(posedge clk_i); #1;
        check_outputs();
        rst_i = 1'b0;
        tick(0, 0, 0, 1, 0, memf(32'h300));
        chk("late_valid", 32'(IF_IDvalid_o), 32'd0);
        chk("late_addr", imem_addr_o, 32'h0);

        // randomized traffic with variable response latency
        tb_out = 0; tb_dly = 0; tb_addr = '0;
        for (int c = 0; c < 3000; c++) begin
            bit          hz  = ($urandom_range(0, 9) < 3);
            bit          fl  = ($urandom_range(0, 19) == 0);
            bit          gnt = ($urandom_range(0, 3) != 0);
            bit          rv  = tb_out && (tb_dly == 0);
            logic [31:0] tgt = $urandom;
            logic [31:0] rd  = rv ? memf(tb_addr) : $urandom;
            if (rv) tb_out = 0;
            else if (tb_out) tb_dly--;
            if (imem_req_o && gnt) begin
                tb_out  = 1;
                tb_addr = imem_addr_o;
                tb_dly  = $urandom_range(0, 2);
            end
            tick(hz, fl, gnt, rv, tgt, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RISC-V core.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Stalls on the load-use hazard signal from the hazard detect unit and redirects on branch/jump flush from EX.
- Drives IF/ID rs1/rs2 fields back into the hazard detect unit.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
XLEN, 32, address/data width (only 32 supported)

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous, active-high reset
Hazard_i  in  1  load-use stall from hazard detect; holds IF/ID and PC
Flush_i  in  1  branch/jump taken in EX; redirect and kill younger instructions
BranchTarget_i  in  32  redirect PC, valid with Flush_i
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address, word aligned
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response data valid
imem_rdata_i  in  32  instruction word
IF_IDpc_o  out  32  PC of instruction in IF/ID
IF_IDinstr_o  out  32  instruction in IF/ID
IF_IDvalid_o  out  1  IF/ID holds a real instruction
IF_IDrs1_o  out  5  instr[19:15]; 0 when invalid
IF_IDrs2_o  out  5  instr[24:20]; 0 when invalid

Behaviour:
- Reset values:
  - pc = RESET_PC; state = REQ; kill = 0; hold buffer empty.
  - imem_req_o = 0 while rst_i is high.
  - IF_IDvalid_o = 0; IF_IDinstr_o = NOP (32'h0000_0013); IF_IDpc_o = 0; rs1/rs2 = 0.
- Reset mid-transaction: all state is discarded immediately. Any memory response arriving after reset release, without a matching post-reset grant, is ignored.
- FSM states REQ, WAIT, HOLD.
- REQ:
  - imem_req_o = 1, imem_addr_o = pc.
  - On gnt: pc_issued <= pc, pc <= pc + 4 (wraps modulo 2^32), go WAIT.
  - Address may change before grant only due to Flush_i.
- WAIT:
  - imem_req_o = 0.
  - On rvalid with kill = 1: drop data, kill <= 0, go REQ.
  - On rvalid with Flush_i: drop data, go REQ.
  - On rvalid with IF/ID free: load IF/ID {pc_issued, rdata, valid = 1}, go REQ. "Free" means !Hazard_i or !IF_IDvalid_o.
  - On rvalid while stalled: capture into 1-entry hold buffer, go HOLD.
- HOLD:
  - imem_req_o = 0.
  - When Hazard_i drops: IF/ID <= hold buffer, buffer empty, go REQ.
- Flush_i, any state:
  - pc <= BranchTarget_i.
  - IF/ID <= {valid 0, NOP}; hold buffer cleared.
  - In WAIT without rvalid: kill <= 1, stay WAIT.
  - In REQ with gnt the same cycle: the granted access is stale, so go WAIT with kill <= 1.
  - In HOLD: go REQ.
- Priority: Flush_i > Hazard_i > new response.
- Hazard_i with no flush: IF/ID holds all fields; pc unchanged except the grant-path increment.
- No response and no stall: IF/ID becomes bubble (valid 0, NOP).
- Latency: gnt in cycle N and rvalid in N+1 give IF/ID valid after the N+1 edge. Best-case throughput is one instruction per 2 cycles (single outstanding).
- BranchTarget_i[1:0] is ignored (forced 0).

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs StallCnt_o[31:0] and FetchCnt_o[31:0], both reset to 0, wrapping.
  - StallCnt_o counts cycles with Hazard_i && IF_IDvalid_o.
  - FetchCnt_o counts responses loaded into IF/ID that were not killed.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR = 32'h0000_0013; RS1_MSB/LSB and RS2_MSB/LSB field constants.
  - Fetch FSM state encoding REQ/WAIT/HOLD.
  - Default RESET_PC.
- One sub-module: if_id_reg. This is the IF/ID register with stall/flush inputs, load data, and valid, plus the rs1/rs2 extraction.

Test Plan:
- Reset release with gnt tied 1 and rvalid one cycle later → addr 0x0, 0x4, 0x8 issued every 2 cycles; IF_IDpc_o steps 0x0, 0x4, 0x8.
- Hazard_i high 3 cycles while instr 0x00B50633 at 0x4 is in IF/ID and the next response arrives → IF/ID stable with rs1 = 10, rs2 = 11; response sits in HOLD; loaded into IF/ID the cycle after Hazard_i falls.
- Flush_i with target 0x100 during WAIT, rvalid next cycle → data dropped, IF_IDvalid_o = 0, next request addr = 0x100.
- Flush_i and Hazard_i asserted together → IF/ID becomes NOP/invalid; flush wins.
- gnt withheld 4 cycles → imem_addr_o stable and req high throughout; pc not incremented.
- rst_i asserted in WAIT → outputs return to reset values asynchronously; first post-reset request addr = RESET_PC.
